// File: rtl/alu_result_collector.sv
// Collects ALU result words into a show-ahead FIFO and tracks sticky flags and result/drop counters.
// Optional macro ALU_COLLECTOR_PARITY_EN stores an even-parity bit per entry and exposes out_parity.
module alu_result_collector #(
  parameter int DATA_W = 64,
  parameter int SEL_W  = 5,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [FLAG_W-1:0]          in_flags,
  input  logic [SEL_W-1:0]           in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [SEL_W-1:0]           out_sel,
`ifdef ALU_COLLECTOR_PARITY_EN
  output logic                       out_parity,
`endif
  output logic [$clog2(DEPTH):0]     level,
  output logic [FLAG_W-1:0]          sticky_flags,
  input  logic                       sticky_clr,
  output logic [CNT_W-1:0]           result_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = SEL_W + FLAG_W + DATA_W;
`ifdef ALU_COLLECTOR_PARITY_EN
  localparam int EW = FW + 1;
`else
  localparam int EW = FW;
`endif

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     lvl;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;
  logic            push;
  logic            pop;

  // Handshake status comes purely from the registered level, so a pop never
  // reopens in_ready within the same cycle.
  assign in_ready  = (lvl != (AW+1)'(DEPTH));
  assign out_valid = (lvl != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = lvl;

`ifdef ALU_COLLECTOR_PARITY_EN
  assign wr_entry = {^{in_sel, in_flags, in_data}, in_sel, in_flags, in_data};
`else
  assign wr_entry = {in_sel, in_flags, in_data};
`endif

  assign head = mem[rd_ptr];
  assign {out_sel, out_flags, out_data} = head[FW-1:0];
`ifdef ALU_COLLECTOR_PARITY_EN
  assign out_parity = head[EW-1];
`endif

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Clear acts before the OR, so clear-with-push leaves just the new flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push ? in_flags : '0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        result_cnt <= result_cnt + 1'b1;
      end
      if (in_valid && !in_ready && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed plus randomized checks of alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [4:0]  sel;
    logic [3:0]  flags;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [3:0]  in_flags = '0;
  logic [4:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_flags;
  logic [4:0]  out_sel;
`ifdef ALU_COLLECTOR_PARITY_EN
  logic        out_parity;
`endif
  logic [3:0]  level;
  logic [3:0]  sticky_flags;
  logic        sticky_clr = 1'b0;
  logic [15:0] result_cnt;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        q[$];
  logic [3:0]  m_sticky = '0;
  int unsigned m_rc = 0;
  int unsigned m_drop = 0;

  always #5 clk = ~clk;

  alu_result_collector #(.DATA_W(64), .SEL_W(5), .FLAG_W(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_flags(in_flags), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .out_sel(out_sel),
`ifdef ALU_COLLECTOR_PARITY_EN
    .out_parity(out_parity),
`endif
    .level(level), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .result_cnt(result_cnt), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("sticky", 64'(sticky_flags), 64'(m_sticky));
    chk("result_cnt", 64'(result_cnt), 64'(m_rc & 32'hFFFF));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (q.size() != 0) begin
      chk("head_data", out_data, q[0].data);
      chk("head_flags", 64'(out_flags), 64'(q[0].flags));
      chk("head_sel", 64'(out_sel), 64'(q[0].sel));
`ifdef ALU_COLLECTOR_PARITY_EN
      chk("head_parity", 64'(out_parity), 64'(^{q[0].sel, q[0].flags, q[0].data}));
`endif
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic cycle(input bit r, input bit v, input logic [63:0] d, input logic [3:0] f,
                       input logic [4:0] s, input bit ordy, input bit clr);
    bit room, push, pop;
    rst = r; in_valid = v; in_data = d; in_flags = f; in_sel = s;
    out_ready = ordy; sticky_clr = clr;
    room = (q.size() < DEPTH);
    push = v && room;
    pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (r) begin
      q.delete(); m_sticky = '0; m_rc = 0; m_drop = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{sel: s, flags: f, data: d});
      if (clr) m_sticky = push ? f : 4'b0;
      else if (push) m_sticky = m_sticky | f;
      if (push) m_rc = m_rc + 1;
      if (v && !room && m_drop < 32'hFFFF) m_drop = m_drop + 1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input bit ordy);
    cycle(0, 0, '0, '0, '0, ordy, 0);
  endtask

  task automatic rnd_push(input bit ordy);
    cycle(0, 1, {$urandom, $urandom}, 4'($urandom), 5'($urandom), ordy, 0);
  endtask

  initial begin
    int unsigned rc0;

    cycle(1, 0, '0, '0, '0, 0, 0);
    cycle(1, 0, '0, '0, '0, 0, 0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    cycle(0, 1, 64'hBAF1_D295_24FD_1EBD, 4'b0010, 5'd3, 0, 0);
    chk("single_data", out_data, 64'hBAF1_D295_24FD_1EBD);
    chk("single_sel", 64'(out_sel), 64'd3);
    chk("single_cnt", 64'(result_cnt), 64'd1);
    chk("single_sticky", 64'(sticky_flags), 64'b0010);
    idle(1);
    chk("single_pop_valid", 64'(out_valid), 64'd0);

    for (int unsigned i = 0; i < 10; i++)
      cycle(0, 1, 64'(i) * 64'h0101_0101_0101_0101, 4'(i), 5'(i), 0, 0);
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_drop", 64'(drop_cnt), 64'd2);
    for (int unsigned i = 0; i < 8; i++) begin
      chk("drain_sel", 64'(out_sel), 64'(i));
      idle(1);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    for (int unsigned i = 0; i < 4; i++) rnd_push(0);
    rc0 = m_rc;
    for (int unsigned i = 0; i < 20; i++) begin
      rnd_push(1);
      chk("conc_level", 64'(level), 64'd4);
    end
    chk("conc_cnt", 64'(result_cnt), 64'((rc0 + 20) & 32'hFFFF));

    cycle(0, 0, '0, '0, '0, 0, 1);
    chk("clr_alone", 64'(sticky_flags), 64'd0);
    cycle(0, 1, 64'h11, 4'b0001, 5'd4, 1, 0);
    cycle(0, 1, 64'h22, 4'b1000, 5'd5, 1, 0);
    chk("sticky_or", 64'(sticky_flags), 64'b1001);
    cycle(0, 1, 64'h33, 4'b0100, 5'd6, 1, 1);
    chk("sticky_clr_push", 64'(sticky_flags), 64'b0100);

    while (q.size() != 0) idle(1);
    for (int unsigned i = 0; i < 5; i++) rnd_push(0);
    chk("pre_rst_level", 64'(level), 64'd5);
    cycle(1, 1, {$urandom, $urandom}, 4'hF, 5'd9, 1, 1);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_cnt", 64'(result_cnt), 64'd0);
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 5'd1, 0, 0);
    chk("ones_head", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef ALU_COLLECTOR_PARITY_EN
    chk("ones_parity", 64'(out_parity), 64'd1);
`endif

    for (int unsigned i = 0; i < 600; i++) begin
      bit phase_fill;
      phase_fill = ((i / 60) % 2) == 0;
      cycle(($urandom % 150) == 0,
            phase_fill ? (($urandom % 4) != 0) : (($urandom % 3) == 0),
            {$urandom, $urandom}, 4'($urandom), 5'($urandom),
            phase_fill ? (($urandom % 3) == 0) : (($urandom % 4) != 0),
            ($urandom % 16) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
Receive-side counterpart to the ALU stimulus path. Accepts each ALU result word, status flags and select code over a valid/ready handshake, and buffers them in a show-ahead FIFO for a downstream checker or host to drain. Also keeps sticky status flags, a result counter and a dropped-result counter for post-run inspection.

Parameters:
DATA_W, 64, ALU result width.
SEL_W, 5, ALU select code width.
FLAG_W, 4, status flag width; bit0 Z, bit1 N, bit2 C, bit3 V.
DEPTH, 8, FIFO entries; power of two, at least 2.
CNT_W, 16, width of the result and drop counters.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  producer presents a result.
in_ready  out  1  collector can accept; equals !full.
in_data  in  DATA_W  ALU result o.
in_flags  in  FLAG_W  ALU status sig.
in_sel  in  SEL_W  select code that produced the result.
out_valid  out  1  FIFO head valid; equals !empty.
out_ready  in  1  consumer pops the head.
out_data  out  DATA_W  head result.
out_flags  out  FLAG_W  head flags.
out_sel  out  SEL_W  head select code.
level  out  $clog2(DEPTH)+1  current occupancy.
sticky_flags  out  FLAG_W  OR of flags over all accepted results.
sticky_clr  in  1  clears sticky_flags.
result_cnt  out  CNT_W  number of accepted results; wraps.
drop_cnt  out  CNT_W  cycles with in_valid && !in_ready; saturates.

Behaviour:
- Reset: level=0, out_valid=0, in_ready=1, sticky_flags=0, result_cnt=0, drop_cnt=0, and both pointers = 0. out_data/out_flags/out_sel are don't-care while out_valid=0 and must not be X-checked.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- Storage: {sel, flags, data} is written at wr_ptr. The head is read combinationally at rd_ptr (show-ahead).
- Latency: a word pushed at edge N is visible on out_* with out_valid=1 after edge N; there is no same-cycle pass-through.
- Pointers are log2(DEPTH) bits and wrap naturally. level is tracked explicitly: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (level==DEPTH): in_ready=0. A simultaneous pop does not raise in_ready in the same cycle; in_ready is registered-style and derived from level.
- Empty: out_valid=0, and out_ready is ignored.
- Push and pop in the same cycle with 0<level<DEPTH: both occur and level is unchanged.
- sticky_flags: on push, sticky |= in_flags. If sticky_clr and push occur in the same cycle, sticky = in_flags (the clear takes effect before the OR). sticky_clr alone gives sticky = 0.
- result_cnt: +1 per push, wraps at 2^CNT_W.
- drop_cnt: +1 on each cycle with in_valid && !in_ready, holding at all-ones. There is no clear other than rst.
- Reset mid-operation: rst asserted on any edge overrides push, pop and clr. All FIFO contents are discarded and the counters are zeroed.
- The producer must hold in_* stable while in_valid && !in_ready. The block does not check this.

Optional Feature:
ALU_COLLECTOR_PARITY_EN:
- Defined: adds output out_parity (1 bit). The even parity of {in_sel, in_flags, in_data} is computed at push and stored alongside the entry. out_parity is presented with the head, so out_parity equals the XOR of the stored fields for an uncorrupted entry.
- Undefined: no out_parity port, no extra storage bit, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst high for 2 cycles -> in_ready=1, out_valid=0, level=0, sticky_flags=0, result_cnt=0, drop_cnt=0.
- Single push: data=64'hBAF1_D295_24FD_1EBD, flags=4'b0010, sel=5'd3 -> out_valid=1 the next cycle with the same fields, level=1, result_cnt=1, sticky=4'b0010. Then pop -> level=0, out_valid=0.
- Fill/overflow with DEPTH=8: push sel=0..9 back-to-back with out_ready=0 -> 8 accepted, in_ready=0 from the cycle after the 8th push, drop_cnt=2. Drain yields sel 0..7 in order.
- Concurrent push/pop at level=4 for 20 cycles -> level stays 4, output order is preserved, and result_cnt increases by 20.
- Sticky: push flags 4'b0001 then 4'b1000 -> sticky=4'b1001. Assert sticky_clr with a push of flags 4'b0100 -> sticky=4'b0100.
- Mid-run reset: with level=5, assert rst one cycle -> level=0, out_valid=0, counters 0. Then push data=64'hFFFF_FFFF_FFFF_FFFF -> it appears as the head the next cycle. With ALU_COLLECTOR_PARITY_EN, out_parity=1 for data all-ones with flags=4'b0000 and sel=5'd1.
